// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus launch sequencer feeding the UART transmitter.
// Host pushes bytes; one byte at a time is launched on newd/dintx, and the
// next launch waits for donetx (or a stuck-transmitter timeout).
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr_en, wr_data   host write strobe and byte
//   full, empty      FIFO status decoded from count
//   count            bytes stored (0..DEPTH)
//   overflow         1-cycle pulse, write dropped because full
//   newd, dintx      launch request and byte to the transmitter
//   donetx           transmitter frame-complete pulse
//   tx_busy          sequencer not idle
//   tx_timeout       1-cycle pulse, donetx never arrived
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       newd,
    output logic [7:0]                 dintx,
    input  logic                       donetx,
    output logic                       tx_busy,
    output logic                       tx_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(12 * CLKS_PER_BIT);

    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(12 * CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          avail_q, avail_d;
    logic          newd_q, newd_d;
    logic [7:0]    dintx_q, dintx_d;
    logic          timeout_q, timeout_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] to_q, to_d;

    logic          push;
    logic          pop;

    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign newd       = newd_q;
    assign dintx      = dintx_q;
    assign tx_busy    = (state_q != IDLE);
    assign tx_timeout = timeout_q;

    // A full FIFO rejects writes even when a pop lands in the same cycle.
    assign push = wr_en && !full;

    always_comb begin
        overflow_d = wr_en && full;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        count_d    = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        // Registered non-empty flag: the sequencer reacts one cycle after
        // count rises, so a first write launches two edges later.
        avail_d    = !empty;
    end

    always_comb begin
        state_d   = state_q;
        newd_d    = newd_q;
        dintx_d   = dintx_q;
        hold_d    = hold_q;
        to_d      = to_q;
        timeout_d = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (avail_q && !empty) begin
                    pop     = 1'b1;
                    dintx_d = mem_q[rptr_q];
                    newd_d  = 1'b1;
                    hold_d  = '0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                // newd held a full bit time so the baud tick sees it.
                if (hold_q == HOLD_LAST) begin
                    newd_d  = 1'b0;
                    to_d    = '0;
                    state_d = WAIT;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            WAIT: begin
                if (donetx) begin
                    state_d = GAP;
                end else if (to_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            avail_q    <= 1'b0;
            newd_q     <= 1'b0;
            dintx_q    <= 8'h00;
            timeout_q  <= 1'b0;
            hold_q     <= '0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            avail_q    <= avail_d;
            newd_q     <= newd_d;
            dintx_q    <= dintx_d;
            timeout_q  <= timeout_d;
            hold_q     <= hold_d;
            to_q       <= to_d;
        end
    end

endmodule
